// File: rtl/router_pkg.sv
// Shared router constants and types, common to the FSM, FIFO, sync and register blocks.
package router_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef logic [DATA_W-1:0] data_t;

    function automatic logic addr_valid(input data_t hdr);
        return hdr[ADDR_W-1:0] != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity of the packet, captured parity byte and the error compare.
module router_parity_chk
    import router_pkg::*;
(
    input  logic  clock,
    input  logic  resetn,
    input  logic  clear,
    input  logic  xor_en,
    input  data_t xor_data,
    input  logic  capture,
    input  data_t capture_data,
    input  logic  compare,
    output logic  parity_done,
    output logic  err
);

    data_t internal_parity_q, internal_parity_d;
    data_t packet_parity_q, packet_parity_d;
    logic  parity_done_q, parity_done_d;
    logic  err_q, err_d;

    always_comb begin
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        parity_done_d     = parity_done_q;
        err_d             = err_q;

        if (clear) begin
            internal_parity_d = '0;
        end else if (xor_en) begin
            internal_parity_d = internal_parity_q ^ xor_data;
        end

        if (capture) begin
            packet_parity_d = capture_data;
        end

        // A new header always wins over a late parity capture.
        if (clear) begin
            parity_done_d = 1'b0;
        end else if (capture) begin
            parity_done_d = 1'b1;
        end

        if (clear) begin
            err_d = 1'b0;
        end else if (compare && parity_done_q) begin
            err_d = (internal_parity_q != packet_parity_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            parity_done_q     <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            parity_done_q     <= parity_done_d;
            err_q             <= err_d;
        end
    end

    assign parity_done = parity_done_q;
    assign err         = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register: header/full-hold capture, FIFO write byte and packet parity checking.
module router_reg
    import router_pkg::*;
(
    input  logic  clock,
    input  logic  resetn,
    input  logic  pkt_valid,
    input  data_t data_in,
    input  logic  fifo_full,
    input  logic  detect_add,
    input  logic  lfd_state,
    input  logic  ld_state,
    input  logic  laf_state,
    input  logic  full_state,
    input  logic  rst_int_reg,
    output data_t dout,
    output logic  parity_done,
    output logic  low_pkt_valid,
    output logic  err
);

    data_t header_byte_q, header_byte_d;
    data_t full_hold_byte_q, full_hold_byte_d;
    data_t dout_q, dout_d;
    logic  low_pkt_valid_q, low_pkt_valid_d;

    logic  hdr_invalid;
    logic  parity_clear;
    logic  parity_xor_en;
    data_t parity_xor_data;
    logic  parity_capture;

    assign hdr_invalid = pkt_valid && !addr_valid(data_in);

    // An invalid-address header must not disturb the previous packet's parity result.
    assign parity_clear    = detect_add && !hdr_invalid;
    assign parity_xor_en   = lfd_state || (ld_state && pkt_valid && !fifo_full);
    assign parity_xor_data = lfd_state ? header_byte_q : data_in;
    assign parity_capture  = (ld_state && !fifo_full && !pkt_valid) ||
                             (laf_state && low_pkt_valid_q && !parity_done);

    always_comb begin
        header_byte_d    = header_byte_q;
        full_hold_byte_d = full_hold_byte_q;
        dout_d           = dout_q;
        low_pkt_valid_d  = low_pkt_valid_q;

        if (detect_add && pkt_valid && addr_valid(data_in)) begin
            header_byte_d = data_in;
        end

        // Nothing in the datapath moves while the controller waits on a full FIFO.
        if (!full_state) begin
            if (lfd_state) begin
                dout_d = header_byte_q;
            end else if (ld_state && !fifo_full) begin
                dout_d = data_in;
            end else if (laf_state) begin
                dout_d = full_hold_byte_q;
            end

            if (ld_state && fifo_full) begin
                full_hold_byte_d = data_in;
            end
        end

        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte_q    <= '0;
            full_hold_byte_q <= '0;
            dout_q           <= '0;
            low_pkt_valid_q  <= 1'b0;
        end else begin
            header_byte_q    <= header_byte_d;
            full_hold_byte_q <= full_hold_byte_d;
            dout_q           <= dout_d;
            low_pkt_valid_q  <= low_pkt_valid_d;
        end
    end

    router_parity_chk u_parity_chk (
        .clock        (clock),
        .resetn       (resetn),
        .clear        (parity_clear),
        .xor_en       (parity_xor_en),
        .xor_data     (parity_xor_data),
        .capture      (parity_capture),
        .capture_data (data_in),
        .compare      (rst_int_reg),
        .parity_done  (parity_done),
        .err          (err)
    );

    assign dout          = dout_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: stimulus queues expected outputs, a monitor checks them.
module tb_router_reg;
    import router_pkg::*;

    logic  clock;
    logic  resetn;
    logic  pkt_valid;
    data_t data_in;
    logic  fifo_full;
    logic  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    data_t dout;
    logic  parity_done, low_pkt_valid, err;

    // State decode vectors: {detect_add, lfd, ld, laf, full, rst_int}
    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_DA   = 6'b100000;
    localparam logic [5:0] ST_LFD  = 6'b010000;
    localparam logic [5:0] ST_LD   = 6'b001000;
    localparam logic [5:0] ST_LAF  = 6'b000100;
    localparam logic [5:0] ST_FULL = 6'b000010;
    localparam logic [5:0] ST_RST  = 6'b000001;

    typedef struct {
        logic [10:0] outs;  // {dout, parity_done, low_pkt_valid, err}
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    router_reg dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare_outs(input logic [10:0] want, input string name);
        logic [10:0] got;
        got = {dout, parity_done, low_pkt_valid, err};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got dout=%h pd=%b lpv=%b err=%b, want dout=%h pd=%b lpv=%b err=%b",
                     name, got[10:3], got[2], got[1], got[0],
                     want[10:3], want[2], want[1], want[0]);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare_outs(e.outs, e.name);
        end
    end

    // Drive one cycle of inputs at a negedge; expected outputs are those after the next posedge.
    task automatic cyc(input logic [5:0] st, input logic pv, input data_t d, input logic ff,
                       input logic [10:0] want, input string name);
        exp_t e;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        pkt_valid = pv;
        data_in   = d;
        fifo_full = ff;
        e.outs = want;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = ST_NONE;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        fifo_full = 1'b0;
        @(negedge clock);
        compare_outs({8'h00, 3'b000}, "reset_state");
        resetn = 1'b1;

        // Good packet: 0D, 11, 22, 33, parity 0D
        cyc(ST_DA,   1'b1, 8'h0D, 1'b0, {8'h00, 3'b000}, "good_hdr");
        cyc(ST_LFD,  1'b1, 8'h11, 1'b0, {8'h0D, 3'b000}, "good_lfd");
        cyc(ST_LD,   1'b1, 8'h11, 1'b0, {8'h11, 3'b000}, "good_p0");
        cyc(ST_LD,   1'b1, 8'h22, 1'b0, {8'h22, 3'b000}, "good_p1");
        cyc(ST_LD,   1'b1, 8'h33, 1'b0, {8'h33, 3'b000}, "good_p2");
        cyc(ST_LD,   1'b0, 8'h0D, 1'b0, {8'h0D, 3'b110}, "good_parity");
        cyc(ST_RST,  1'b0, 8'h00, 1'b0, {8'h0D, 3'b100}, "good_check");
        cyc(ST_DA,   1'b0, 8'h00, 1'b0, {8'h0D, 3'b000}, "good_idle");

        // Bad parity byte 0E
        cyc(ST_DA,   1'b1, 8'h0D, 1'b0, {8'h0D, 3'b000}, "bad_hdr");
        cyc(ST_LFD,  1'b1, 8'h11, 1'b0, {8'h0D, 3'b000}, "bad_lfd");
        cyc(ST_LD,   1'b1, 8'h11, 1'b0, {8'h11, 3'b000}, "bad_p0");
        cyc(ST_LD,   1'b1, 8'h22, 1'b0, {8'h22, 3'b000}, "bad_p1");
        cyc(ST_LD,   1'b1, 8'h33, 1'b0, {8'h33, 3'b000}, "bad_p2");
        cyc(ST_LD,   1'b0, 8'h0E, 1'b0, {8'h0E, 3'b110}, "bad_parity");
        cyc(ST_RST,  1'b0, 8'h00, 1'b0, {8'h0E, 3'b101}, "bad_err_set");
        cyc(ST_NONE, 1'b0, 8'h00, 1'b0, {8'h0E, 3'b101}, "bad_err_hold");

        // Invalid address 0F: header and parity state untouched, dout unchanged
        cyc(ST_DA,   1'b1, 8'h0F, 1'b0, {8'h0E, 3'b101}, "inv_hdr");
        cyc(ST_LFD,  1'b0, 8'h00, 1'b0, {8'h0D, 3'b101}, "inv_hdr_kept");
        cyc(ST_DA,   1'b0, 8'h00, 1'b0, {8'h0D, 3'b000}, "err_cleared");

        // Full stall on 22; the stalled source re-presents 22 once the FIFO drains
        cyc(ST_DA,   1'b1, 8'h0D, 1'b0, {8'h0D, 3'b000}, "full_hdr");
        cyc(ST_LFD,  1'b1, 8'h11, 1'b0, {8'h0D, 3'b000}, "full_lfd");
        cyc(ST_LD,   1'b1, 8'h11, 1'b0, {8'h11, 3'b000}, "full_p0");
        cyc(ST_LD,   1'b1, 8'h22, 1'b1, {8'h11, 3'b000}, "full_stall");
        cyc(ST_FULL, 1'b1, 8'h22, 1'b1, {8'h11, 3'b000}, "full_wait");
        cyc(ST_LAF,  1'b1, 8'h22, 1'b0, {8'h22, 3'b000}, "full_laf");
        cyc(ST_LD,   1'b1, 8'h22, 1'b0, {8'h22, 3'b000}, "full_p1");
        cyc(ST_LD,   1'b1, 8'h33, 1'b0, {8'h33, 3'b000}, "full_p2");
        cyc(ST_LD,   1'b0, 8'h0D, 1'b0, {8'h0D, 3'b110}, "full_parity");
        cyc(ST_RST,  1'b0, 8'h00, 1'b0, {8'h0D, 3'b100}, "full_check");
        cyc(ST_DA,   1'b0, 8'h00, 1'b0, {8'h0D, 3'b000}, "full_idle");

        // Parity byte arrives while FIFO full: captured in laf_state, only once
        cyc(ST_DA,   1'b1, 8'h0D, 1'b0, {8'h0D, 3'b000}, "lpv_hdr");
        cyc(ST_LFD,  1'b1, 8'h11, 1'b0, {8'h0D, 3'b000}, "lpv_lfd");
        cyc(ST_LD,   1'b1, 8'h11, 1'b0, {8'h11, 3'b000}, "lpv_p0");
        cyc(ST_LD,   1'b1, 8'h22, 1'b0, {8'h22, 3'b000}, "lpv_p1");
        cyc(ST_LD,   1'b1, 8'h33, 1'b0, {8'h33, 3'b000}, "lpv_p2");
        cyc(ST_LD,   1'b0, 8'h0D, 1'b1, {8'h33, 3'b010}, "lpv_full_parity");
        cyc(ST_FULL, 1'b0, 8'h0D, 1'b1, {8'h33, 3'b010}, "lpv_wait");
        cyc(ST_LAF,  1'b0, 8'h0D, 1'b0, {8'h0D, 3'b110}, "lpv_laf_capture");
        cyc(ST_LAF,  1'b0, 8'hAA, 1'b0, {8'h0D, 3'b110}, "lpv_laf_again");
        cyc(ST_RST,  1'b0, 8'h00, 1'b0, {8'h0D, 3'b100}, "lpv_check");
        cyc(ST_DA,   1'b0, 8'h00, 1'b0, {8'h0D, 3'b000}, "lpv_idle");

        // Reset mid-payload, then a clean packet 0A, 5A, C3, parity 93
        cyc(ST_DA,   1'b1, 8'h0A, 1'b0, {8'h0D, 3'b000}, "rst_hdr");
        cyc(ST_LFD,  1'b1, 8'h5A, 1'b0, {8'h0A, 3'b000}, "rst_lfd");
        cyc(ST_LD,   1'b1, 8'h5A, 1'b0, {8'h5A, 3'b000}, "rst_p0");
        resetn = 1'b0;
        #1;
        compare_outs({8'h00, 3'b000}, "async_reset");
        @(negedge clock);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = ST_NONE;
        resetn = 1'b1;
        cyc(ST_NONE, 1'b1, 8'hC3, 1'b0, {8'h00, 3'b000}, "post_reset_idle");
        cyc(ST_DA,   1'b1, 8'h0A, 1'b0, {8'h00, 3'b000}, "post_hdr");
        cyc(ST_LFD,  1'b1, 8'h5A, 1'b0, {8'h0A, 3'b000}, "post_lfd");
        cyc(ST_LD,   1'b1, 8'h5A, 1'b0, {8'h5A, 3'b000}, "post_p0");
        cyc(ST_LD,   1'b1, 8'hC3, 1'b0, {8'hC3, 3'b000}, "post_p1");
        cyc(ST_LD,   1'b0, 8'h93, 1'b0, {8'h93, 3'b110}, "post_parity");
        cyc(ST_RST,  1'b0, 8'h00, 1'b0, {8'h93, 3'b100}, "post_check");
        cyc(ST_NONE, 1'b0, 8'h00, 1'b0, {8'h93, 3'b100}, "post_hold");

        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
